// File: rtl/cpu_writeback_pkg.sv
// Shared types for the risc16 core: register-file write task, memory-to-writeback
// task, write-back source select and the write-back FSM state encoding.
package risc16;

    localparam int REG_ADDR_WIDTH = 3;
    localparam int REG_DATA_WIDTH = 16;

    typedef struct packed {
        logic                      wr_en;
        logic [REG_ADDR_WIDTH-1:0] reg_addr;
        logic [REG_DATA_WIDTH-1:0] wr_data;
    } wb_task_t;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'b00,
        WB_SRC_PC1 = 2'b01,
        WB_SRC_MEM = 2'b10
    } wb_src_t;

    typedef struct packed {
        logic                      wr_en;
        logic [REG_ADDR_WIDTH-1:0] reg_addr;
        wb_src_t                   src_sel;
        logic [REG_DATA_WIDTH-1:0] alu_data;
        logic [REG_DATA_WIDTH-1:0] pc;
    } mem_wb_task_t;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_t;

    // A write reaches the register file only when enabled and not aimed at r0.
    function automatic logic writes_reg(input logic wr_en, input logic [REG_ADDR_WIDTH-1:0] addr);
        return wr_en && (addr != {REG_ADDR_WIDTH{1'b0}});
    endfunction

    // Non-load write-back data; unknown selects fall back to the ALU result.
    function automatic logic [REG_DATA_WIDTH-1:0] direct_data(input mem_wb_task_t t);
        logic [REG_DATA_WIDTH-1:0] d;
        case (t.src_sel)
            WB_SRC_PC1: d = t.pc + 16'd1;
            WB_SRC_ALU: d = t.alu_data;
            default:    d = t.alu_data;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpu_writeback.sv
// Write-back stage: retires ALU/PC+1 results in one cycle and holds the pipeline
// while a load waits for its data, producing a registered register-file write task.
module cpu_writeback
    import risc16::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  mem_wb_task_t              in_task_i,
    input  logic                      dmem_rvalid_i,
    input  logic [REG_DATA_WIDTH-1:0] dmem_rdata_i,
    output wb_task_t                  task_o,
    output logic                      pend_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] pend_addr_o,
    output logic [15:0]               retired_o,
    output logic                      err_o
);

    wb_state_t                 state_r;
    wb_state_t                 state_next_s;
    wb_task_t                  task_r;
    logic                      ld_wr_en_r;
    logic [REG_ADDR_WIDTH-1:0] ld_addr_r;
    logic [15:0]               retired_r;
    logic                      err_r;

    logic                      retire_s;
    logic                      latch_s;
    logic                      ret_wr_en_s;
    logic [REG_ADDR_WIDTH-1:0] ret_addr_s;
    logic [REG_DATA_WIDTH-1:0] ret_data_s;

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and the instruction retiring on this edge, if any.
    always_comb begin
        state_next_s = state_r;
        retire_s     = 1'b0;
        latch_s      = 1'b0;
        ret_wr_en_s  = 1'b0;
        ret_addr_s   = {REG_ADDR_WIDTH{1'b0}};
        ret_data_s   = {REG_DATA_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (in_valid_i) begin
                    if (in_task_i.src_sel == WB_SRC_MEM) begin
                        state_next_s = ST_WAIT_LOAD;
                        latch_s      = 1'b1;
                    end else begin
                        retire_s    = 1'b1;
                        ret_wr_en_s = in_task_i.wr_en;
                        ret_addr_s  = in_task_i.reg_addr;
                        ret_data_s  = direct_data(in_task_i);
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                if (dmem_rvalid_i) begin
                    state_next_s = ST_IDLE;
                    retire_s     = 1'b1;
                    ret_wr_en_s  = ld_wr_en_r;
                    ret_addr_s   = ld_addr_r;
                    ret_data_s   = dmem_rdata_i;
                end else begin
                    state_next_s = ST_WAIT_LOAD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Write task, pending-load latch, retire counter and sticky error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            task_r     <= '0;
            ld_wr_en_r <= 1'b0;
            ld_addr_r  <= {REG_ADDR_WIDTH{1'b0}};
            retired_r  <= 16'd0;
            err_r      <= 1'b0;
        end else begin
            task_r.wr_en <= retire_s && writes_reg(ret_wr_en_s, ret_addr_s);
            // Suppressed or absent writes leave address and data untouched.
            if (retire_s && writes_reg(ret_wr_en_s, ret_addr_s)) begin
                task_r.reg_addr <= ret_addr_s;
                task_r.wr_data  <= ret_data_s;
            end
            if (retire_s) begin
                retired_r <= retired_r + 16'd1;
            end
            if (latch_s) begin
                ld_wr_en_r <= in_task_i.wr_en;
                ld_addr_r  <= in_task_i.reg_addr;
            end else if ((state_r == ST_WAIT_LOAD) && dmem_rvalid_i) begin
                ld_wr_en_r <= 1'b0;
                ld_addr_r  <= {REG_ADDR_WIDTH{1'b0}};
            end
            if (dmem_rvalid_i && (state_r == ST_IDLE)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign in_ready_o   = (state_r == ST_IDLE);
    assign pend_valid_o = (state_r == ST_WAIT_LOAD);
    assign pend_addr_o  = ld_addr_r;
    assign task_o       = task_r;
    assign retired_o    = retired_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_cpu_writeback.sv
// Randomised and directed bench for cpu_writeback against a behavioural model.
module tb_cpu_writeback;
    import risc16::*;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    mem_wb_task_t in_task_i;
    logic         dmem_rvalid_i;
    logic [15:0]  dmem_rdata_i;
    wb_task_t     task_o;
    logic         pend_valid_o;
    logic [2:0]   pend_addr_o;
    logic [15:0]  retired_o;
    logic         err_o;

    int total = 0;
    int bad   = 0;

    // Model: outstanding-load flag plus the expected visible outputs.
    bit          m_pend;
    bit          m_ld_wr;
    logic [2:0]  m_ld_addr;
    bit          m_wr;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    logic [15:0] m_ret;
    bit          m_err;

    cpu_writeback dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_task_i(in_task_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .task_o(task_o), .pend_valid_o(pend_valid_o), .pend_addr_o(pend_addr_o),
        .retired_o(retired_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pend = 1'b0; m_ld_wr = 1'b0; m_ld_addr = 3'd0;
        m_wr = 1'b0; m_addr = 3'd0; m_data = 16'd0; m_ret = 16'd0; m_err = 1'b0;
    endtask

    task automatic compare_all();
        chk("wr_en",      {31'd0, task_o.wr_en}, {31'd0, m_wr});
        chk("reg_addr",   {29'd0, task_o.reg_addr}, {29'd0, m_addr});
        chk("wr_data",    {16'd0, task_o.wr_data}, {16'd0, m_data});
        chk("pend_valid", {31'd0, pend_valid_o}, {31'd0, m_pend});
        chk("pend_addr",  {29'd0, pend_addr_o}, m_pend ? {29'd0, m_ld_addr} : 32'd0);
        chk("retired",    {16'd0, retired_o}, {16'd0, m_ret});
        chk("err",        {31'd0, err_o}, {31'd0, m_err});
        chk("in_ready",   {31'd0, in_ready_o}, {31'd0, !m_pend});
    endtask

    task automatic drive(input bit v, input bit w, input logic [2:0] a, input wb_src_t s,
                         input logic [15:0] alu, input logic [15:0] pc,
                         input bit rv, input logic [15:0] rd);
        in_valid_i         = v;
        in_task_i.wr_en    = w;
        in_task_i.reg_addr = a;
        in_task_i.src_sel  = s;
        in_task_i.alu_data = alu;
        in_task_i.pc       = pc;
        dmem_rvalid_i      = rv;
        dmem_rdata_i       = rd;
    endtask

    // One clock: predict from the present inputs, step the edge, then compare.
    task automatic cycle();
        bit          ret = 1'b0;
        bit          w   = 1'b0;
        logic [2:0]  a   = 3'd0;
        logic [15:0] d   = 16'd0;
        chk("in_ready_pre", {31'd0, in_ready_o}, {31'd0, !m_pend});
        if (m_pend) begin
            if (dmem_rvalid_i) begin
                ret = 1'b1; w = m_ld_wr; a = m_ld_addr; d = dmem_rdata_i;
                m_pend = 1'b0;
            end
        end else begin
            if (dmem_rvalid_i) m_err = 1'b1;
            if (in_valid_i) begin
                if (in_task_i.src_sel == WB_SRC_MEM) begin
                    m_pend = 1'b1; m_ld_wr = in_task_i.wr_en; m_ld_addr = in_task_i.reg_addr;
                end else begin
                    ret = 1'b1; w = in_task_i.wr_en; a = in_task_i.reg_addr;
                    d = (in_task_i.src_sel == WB_SRC_PC1) ? (in_task_i.pc + 16'd1) : in_task_i.alu_data;
                end
            end
        end
        if (ret) m_ret = m_ret + 16'd1;
        m_wr = ret && w && (a != 3'd0);
        if (m_wr) begin
            m_addr = a; m_data = d;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        m_reset();
        #1;
        compare_all();
        @(posedge clk);
        #4;
        rst_i = 1'b0;
    endtask

    initial begin
        int streak;
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 3'd0, WB_SRC_ALU, 16'd0, 16'd0, 1'b0, 16'd0);
        m_reset();
        #12;
        compare_all();
        chk("rst_retired", {16'd0, retired_o}, 32'd0);
        chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
        #2 rst_i = 1'b0;

        drive(1'b1, 1'b1, 3'd3, WB_SRC_ALU, 16'h1234, 16'h0000, 1'b0, 16'd0);
        cycle();
        chk("alu_wr_en", {31'd0, task_o.wr_en}, 32'd1);
        chk("alu_addr", {29'd0, task_o.reg_addr}, 32'd3);
        chk("alu_data", {16'd0, task_o.wr_data}, 32'h1234);
        chk("alu_retired", {16'd0, retired_o}, 32'd1);

        drive(1'b1, 1'b1, 3'd7, WB_SRC_PC1, 16'h5555, 16'hFFFF, 1'b0, 16'd0);
        cycle();
        chk("jalr_data", {16'd0, task_o.wr_data}, 32'h0000);
        chk("jalr_addr", {29'd0, task_o.reg_addr}, 32'd7);

        drive(1'b1, 1'b1, 3'd5, WB_SRC_MEM, 16'h0000, 16'h0000, 1'b0, 16'd0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 3'd2, WB_SRC_ALU, 16'hAAAA, 16'h0000, 1'b0, 16'd0);
            chk("ld_pend", {31'd0, pend_valid_o}, 32'd1);
            chk("ld_pend_addr", {29'd0, pend_addr_o}, 32'd5);
            chk("ld_ready", {31'd0, in_ready_o}, 32'd0);
            cycle();
        end
        drive(1'b0, 1'b0, 3'd0, WB_SRC_ALU, 16'd0, 16'd0, 1'b1, 16'hBEEF);
        cycle();
        chk("ld_wr_en", {31'd0, task_o.wr_en}, 32'd1);
        chk("ld_addr", {29'd0, task_o.reg_addr}, 32'd5);
        chk("ld_data", {16'd0, task_o.wr_data}, 32'hBEEF);
        chk("ld_ready_after", {31'd0, in_ready_o}, 32'd1);

        drive(1'b1, 1'b1, 3'd0, WB_SRC_ALU, 16'hFFFF, 16'd0, 1'b0, 16'd0);
        cycle();
        chk("r0_wr_en", {31'd0, task_o.wr_en}, 32'd0);
        chk("r0_retired", {16'd0, retired_o}, 32'd4);
        chk("r0_data_held", {16'd0, task_o.wr_data}, 32'hBEEF);

        drive(1'b0, 1'b0, 3'd0, WB_SRC_ALU, 16'd0, 16'd0, 1'b1, 16'h1111);
        cycle();
        chk("err_set", {31'd0, err_o}, 32'd1);
        chk("err_no_write", {31'd0, task_o.wr_en}, 32'd0);
        drive(1'b0, 1'b0, 3'd0, WB_SRC_ALU, 16'd0, 16'd0, 1'b0, 16'd0);
        cycle();
        cycle();
        chk("err_sticky", {31'd0, err_o}, 32'd1);

        drive(1'b1, 1'b1, 3'd6, WB_SRC_MEM, 16'd0, 16'd0, 1'b0, 16'd0);
        cycle();
        drive(1'b0, 1'b0, 3'd0, WB_SRC_ALU, 16'd0, 16'd0, 1'b0, 16'd0);
        cycle();
        chk("mid_pend", {31'd0, pend_valid_o}, 32'd1);
        #3 rst_i = 1'b1;
        m_reset();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 16'hCAFE;
        #1;
        compare_all();
        chk("mid_rst_retired", {16'd0, retired_o}, 32'd0);
        chk("mid_rst_pend_addr", {29'd0, pend_addr_o}, 32'd0);
        @(posedge clk);
        #1;
        compare_all();
        #3 rst_i = 1'b0;
        cycle();
        chk("late_rvalid_err", {31'd0, err_o}, 32'd1);
        chk("late_rvalid_no_wr", {31'd0, task_o.wr_en}, 32'd0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rv;
            rv = m_pend ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  wb_src_t'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), rv, 16'($urandom));
            cycle();
        end

        do_reset();
        streak = 0;
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 1'b1, 3'($urandom_range(1, 7)), WB_SRC_ALU, 16'($urandom), 16'd0, 1'b0, 16'd0);
            cycle();
            if (task_o.wr_en === 1'b1) streak++;
            else streak = 0;
        end
        chk("tput_streak", streak, 32'd65537);
        chk("tput_wrap", {16'd0, retired_o}, 32'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
